div_seq_signed: RTL

//  Multi-cycle signed 32-bit integer divider for the ALU/multdiv path.
//  It is the inverse counterpart of the carry-lookahead adder: each cycle it does a

---
 rtl/alu_pkg.sv | 10 +
 rtl/div_seq_signed_if.sv | 13 +
 rtl/div_trial_sub.sv | 9 +
 rtl/div_seq_signed.sv | 52 +++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and divider state encodings
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam int DIV_CW = $clog2(ALU_WIDTH);
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_seq_signed_if.sv
// div_seq_signed_if: start/operand and result/handshake bundle for the sequential divider
interface div_seq_signed_if import alu_pkg::*; #(parameter int WIDTH = ALU_WIDTH);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  modport master (output ctrl_DIV, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY);
  modport slave  (input  ctrl_DIV, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY);
endinterface

// File: rtl/div_trial_sub.sv
// div_trial_sub: restoring trial subtract a - b (invert b, carry-in 1); ge is the carry out (no borrow)
module div_trial_sub #(parameter int N = 33) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         ge
);
  always_comb {ge, diff} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
endmodule

// File: rtl/div_seq_signed.sv
// div_seq_signed: signed restoring divider, one quotient bit per cycle, RDY WIDTH+1 edges after start
module div_seq_signed import alu_pkg::*; #(parameter int WIDTH = ALU_WIDTH) (
  input logic clock,
  input logic reset,
  div_seq_signed_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state_q, state_d;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] rem, rem_sh, diff;
  logic [WIDTH-1:0] dvd, dsr, q, result;
  logic qsign, dz, exc, rdy, ge;
  assign rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  assign bus.data_result = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;
  div_trial_sub #(.N(WIDTH+1)) u_sub (.a(rem_sh), .b({1'b0, dsr}), .diff(diff), .ge(ge));
  always_comb begin
    state_d = state_q;
    state_d = bus.ctrl_DIV ? DIV_RUN
            : state_q == DIV_RUN ? (cnt == CW'(WIDTH-1) ? DIV_DONE : DIV_RUN)
            : DIV_IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= DIV_IDLE;
    else state_q <= state_d;
  // a start on any state, including DONE, restarts and suppresses the pending result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0; rem <= '0; dvd <= '0; dsr <= '0; q <= '0;
      qsign <= 1'b0; dz <= 1'b0; result <= '0; exc <= 1'b0; rdy <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      dvd <= bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
      dsr <= bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
      qsign <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz <= bus.data_operandB == '0;
      rem <= '0; q <= '0; cnt <= '0; rdy <= 1'b0;
    end else begin
      rdy <= state_q == DIV_DONE;
      if (state_q == DIV_RUN) begin
        rem <= ge ? diff : rem_sh;
        dvd <= dvd << 1;
        q <= {q[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state_q == DIV_DONE) begin
        result <= dz ? '0 : qsign ? -q : q;
        exc <= dz;
      end
    end
  end
endmodule
